rc4_xor_stage: RTL

Keystream combiner that sits directly downstream of the RC4 PRGA core. It buffers keystream bytes in a small FIFO and XORs them with message bytes from the data path. It emits framed ciphertext (or plaintext, when decrypting) on a valid/ready output, one byte per cycle at full throughput.

---
 rtl/rc4_xor_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rc4_xor_stage.sv
// Keystream combiner: buffers RC4 PRGA bytes in a small FIFO and XORs them with message bytes.
// Optional RC4_DROP_EN discards the first DROP_N keystream bytes of every message.
module rc4_xor_stage #(
  parameter int unsigned KS_FIFO_DEPTH = 4,
  parameter int unsigned DROP_N        = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ks_valid,
  input  logic [7:0]  ks_data,
  output logic        ks_ready,
  input  logic        msg_start,
  input  logic [15:0] msg_len,
  input  logic        din_valid,
  input  logic [7:0]  din_data,
  output logic        din_ready,
  output logic        dout_valid,
  output logic [7:0]  dout_data,
  output logic        dout_last,
  input  logic        dout_ready,
  output logic        busy,
  output logic [15:0] byte_cnt
);

  localparam int unsigned AddrW = (KS_FIFO_DEPTH > 1) ? $clog2(KS_FIFO_DEPTH) : 1;

  if ((KS_FIFO_DEPTH < 2) || ((KS_FIFO_DEPTH & (KS_FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("KS_FIFO_DEPTH must be a power of two and at least 2");
  end
  if (DROP_N < 1) begin : g_drop_chk
    $error("DROP_N must be at least 1");
  end

`ifdef RC4_DROP_EN
  typedef enum logic [1:0] {StIdle, StDrop, StRun, StDrain} state_e;
  localparam int unsigned DropW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
`endif

  state_e state_q, state_d;

  // Keystream FIFO
  logic [7:0]       fifo_mem [KS_FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   fifo_cnt_q, fifo_cnt_d;
  logic             fifo_full, fifo_nonempty, fifo_push, fifo_pop;
  logic [7:0]       fifo_head;

  logic [15:0] rem_cnt_q, rem_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        busy_q, busy_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dout_last_q, dout_last_d;
  logic [7:0]  dout_data_q, dout_data_d;

  logic start_ok, din_accept, out_hs;

  assign fifo_full     = (fifo_cnt_q == (AddrW + 1)'(KS_FIFO_DEPTH));
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign fifo_head     = fifo_mem[rd_ptr_q];
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign ks_ready      = rst_n && !fifo_full;
  assign fifo_push     = ks_valid && ks_ready;

  assign start_ok   = msg_start && (msg_len != 16'd0);
  assign out_hs     = dout_valid_q && dout_ready;
  assign din_accept = din_valid && din_ready;

  always_comb begin
    unique case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (AddrW + 1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (AddrW + 1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= ks_data;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
`ifdef RC4_DROP_EN
          state_d = StDrop;
`else
          state_d = StRun;
`endif
        end
      end
`ifdef RC4_DROP_EN
      StDrop: begin
        if (fifo_nonempty && (drop_cnt_q == DropW'(DROP_N - 1))) state_d = StRun;
      end
`endif
      StRun: begin
        if (din_accept && (rem_cnt_q == 16'd1)) state_d = StDrain;
      end
      StDrain: begin
        if (out_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    din_ready = rst_n && (state_q == StRun) && fifo_nonempty && (!dout_valid_q || dout_ready);
`ifdef RC4_DROP_EN
    fifo_pop  = (din_valid && din_ready) || ((state_q == StDrop) && fifo_nonempty);
`else
    fifo_pop  = din_valid && din_ready;
`endif
  end

  always_comb begin
    rem_cnt_d    = rem_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    busy_d       = busy_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_data_d  = dout_data_q;
`ifdef RC4_DROP_EN
    drop_cnt_d   = drop_cnt_q;
    if ((state_q == StDrop) && fifo_nonempty) drop_cnt_d = drop_cnt_q + DropW'(1);
`endif
    if ((state_q == StIdle) && start_ok) begin
      rem_cnt_d  = msg_len;
      byte_cnt_d = 16'd0;
      busy_d     = 1'b1;
`ifdef RC4_DROP_EN
      drop_cnt_d = '0;
`endif
    end
    if (out_hs) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      if (state_q == StDrain) busy_d = 1'b0;
    end
    // A new byte may load in the same cycle the held one is accepted.
    if (din_accept) begin
      dout_data_d  = din_data ^ fifo_head;
      dout_valid_d = 1'b1;
      dout_last_d  = (rem_cnt_q == 16'd1);
      rem_cnt_d    = rem_cnt_q - 16'd1;
      byte_cnt_d   = byte_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_data_q  <= '0;
`ifdef RC4_DROP_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      rem_cnt_q    <= rem_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      busy_q       <= busy_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_data_q  <= dout_data_d;
`ifdef RC4_DROP_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
